// File: rtl/alu_pkg.sv
// Shared opcode and flag definitions for the pipelined ALU (alu_pipe / alu_core).
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 3'b000;
    localparam alu_op_t ALU_SUB = 3'b001;
    localparam alu_op_t ALU_AND = 3'b010;
    localparam alu_op_t ALU_OR  = 3'b011;
    localparam alu_op_t ALU_XOR = 3'b100;
    localparam alu_op_t ALU_SLT = 3'b101;
    localparam alu_op_t ALU_SLL = 3'b110;
    localparam alu_op_t ALU_SRL = 3'b111;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and zero/negative/carry/overflow flags.
// Optional build macro ALU_SAT_EN makes ADD/SUB saturate on signed overflow.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Clamp toward the sign of A: both operands share that sign when overflow occurs.
    function automatic logic signed [WIDTH-1:0] saturate(
        input logic signed [WIDTH-1:0] wrapped,
        input logic                    a_msb,
        input logic                    ovf
    );
        if (!ovf)
            return wrapped;
        return a_msb ? SMIN : SMAX;
    endfunction

    logic                    sub;
    logic [WIDTH-1:0]        bm;
    logic [WIDTH:0]          sum;
    logic                    ovf;
    logic [SHW-1:0]          shamt;
    logic signed [WIDTH-1:0] arith_res;

    assign sub   = (op == ALU_SUB) || (op == ALU_SLT);
    assign bm    = b ^ {WIDTH{sub}};
    assign sum   = {1'b0, a} + {1'b0, bm} + {{WIDTH{1'b0}}, sub};
    assign ovf   = (a[WIDTH-1] == bm[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign shamt = b[SHW-1:0];

`ifdef ALU_SAT_EN
    assign arith_res = saturate(sum[WIDTH-1:0], a[WIDTH-1], ovf);
`else
    assign arith_res = sum[WIDTH-1:0];
`endif

    always_comb begin
        result         = '0;
        flags          = '0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                result         = arith_res;
                flags.carry    = sum[WIDTH];
                flags.overflow = ovf;
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            ALU_SLL: result = a << shamt;
            ALU_SRL: result = a >> shamt;
            default: result = '0;
        endcase
        flags.zero     = (result == '0);
        flags.negative = result[WIDTH-1];
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake on both sides (alu_core inside).
// Optional build macro ALU_SAT_EN is handled inside alu_core.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Alu_Control,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow
);

    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    alu_op_t          op_p1;
    logic             vld_p1;

    logic [WIDTH-1:0] result_p2;
    alu_flags_t       flags_p2;
    logic             vld_p2;

    logic [WIDTH-1:0] core_result;
    alu_flags_t       core_flags;
    logic             rdy_en;
    logic             adv1;
    logic             adv2;
    logic             accept;

    // rdy_en keeps In_Ready low during reset and for the first edge after release.
    assign adv2     = !vld_p2 || Out_Ready;
    assign adv1     = !vld_p1 || adv2;
    assign In_Ready = adv1 && rdy_en;
    assign accept   = In_Valid && In_Ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdy_en <= 1'b0;
        else
            rdy_en <= 1'b1;
    end

    // Stage 1: operand capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
            op_p1  <= ALU_ADD;
        end else begin
            if (adv1)
                vld_p1 <= accept;
            if (accept) begin
                a_p1  <= A;
                b_p1  <= B;
                op_p1 <= Alu_Control;
            end
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (a_p1),
        .b      (b_p1),
        .op     (op_p1),
        .result (core_result),
        .flags  (core_flags)
    );

    // Stage 2: result and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            flags_p2  <= '0;
        end else begin
            if (adv2)
                vld_p2 <= vld_p1;
            if (adv2 && vld_p1) begin
                result_p2 <= core_result;
                flags_p2  <= core_flags;
            end
        end
    end

    assign Out_Valid = vld_p2;
    assign Result    = result_p2;
    assign Zero      = flags_p2.zero;
    assign Negative  = flags_p2.negative;
    assign Carry     = flags_p2.carry;
    assign Overflow  = flags_p2.overflow;

endmodule
